// File: rtl/infer_frame_host.sv
// rtl/infer_frame_host.sv - frame loader, start/done sequencer and result checker for the Top accelerator
module infer_frame_host #(
  parameter int IMG_WORDS   = 900,
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 32,
  parameter int PS_W        = 4,
  parameter int CNT_W       = 16,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              img_wen,
  output logic [ADDR_W-1:0] img_waddr,
  output logic [DATA_W-1:0] img_wdata,
  output logic              acc_start,
  input  logic              acc_done,
  input  logic [PS_W-1:0]   acc_predict,
  output logic              res_valid,
  output logic [PS_W-1:0]   res_predict,
  output logic [PS_W-1:0]   res_label,
  output logic              res_match,
  output logic              res_timeout,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [CNT_W-1:0]  iter_cnt,
  output logic              busy
);

  localparam int TO_W = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(IMG_WORDS - 1);
  localparam logic [TO_W-1:0]   LAST_TO  = TO_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {LOAD, LABEL, START, WAIT, REPORT} state_t;

  state_t            state;
  state_t            next;
  logic [ADDR_W-1:0] pix_cnt;
  logic [TO_W-1:0]   to_cnt;
  logic [PS_W-1:0]   label_q;
  logic              hs;
  logic              to_hit;

  assign hs     = s_valid & s_ready;
  assign to_hit = (to_cnt == LAST_TO);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= LOAD;
    else     state <= next;
  end

  // Next-state and per-state strobes; all strobes are held low during reset
  always_comb begin
    next      = state;
    s_ready   = 1'b0;
    acc_start = 1'b0;
    res_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      LOAD: begin
        s_ready = !rst;
        if (hs && pix_cnt == LAST_PIX) next = LABEL;
      end
      LABEL: begin
        s_ready = !rst;
        if (hs) next = START;
      end
      START: begin
        acc_start = !rst;
        busy      = !rst;
        next      = WAIT;
      end
      WAIT: begin
        busy = !rst;
        if (acc_done || to_hit) next = REPORT;
      end
      REPORT: begin
        res_valid = !rst;
        next      = LOAD;
      end
      default: next = LOAD;
    endcase
  end

  // Pixel addressing, registered image writes, label capture and the WAIT timeout counter
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_cnt   <= '0;
      to_cnt    <= '0;
      label_q   <= '0;
      img_wen   <= 1'b0;
      img_waddr <= '0;
      img_wdata <= '0;
    end else begin
      img_wen <= (state == LOAD) && hs;
      if (state == LOAD && hs) begin
        img_waddr <= pix_cnt;
        img_wdata <= s_data;
        pix_cnt   <= (pix_cnt == LAST_PIX) ? '0 : pix_cnt + 1'b1;
      end
      if (state == LABEL && hs) label_q <= s_data[PS_W-1:0];
      if (state == START)     to_cnt <= '0;
      else if (state == WAIT) to_cnt <= to_cnt + 1'b1;
    end
  end

  // Result capture when WAIT resolves; label is copied here so all result fields change together
  always_ff @(posedge clk) begin
    if (rst) begin
      res_predict <= '0;
      res_label   <= '0;
      res_match   <= 1'b0;
      res_timeout <= 1'b0;
    end else if (state == WAIT) begin
      if (acc_done) begin
        res_predict <= acc_predict;
        res_label   <= label_q;
        res_match   <= (acc_predict == label_q);
        res_timeout <= 1'b0;
      end else if (to_hit) begin
        res_label   <= label_q;
        res_match   <= 1'b0;
        res_timeout <= 1'b1;
      end
    end
  end

  // Saturating iteration and error counters, updated once per REPORT
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt  <= '0;
      iter_cnt <= '0;
    end else if (state == REPORT) begin
      if (iter_cnt != '1) iter_cnt <= iter_cnt + 1'b1;
      if (!res_match && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_infer_frame_host.sv
// tb/tb_infer_frame_host.sv - directed self-checking bench for infer_frame_host
module tb_infer_frame_host;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid;
  logic [31:0] s_data;
  logic        acc_done;
  logic [3:0]  acc_predict;
  logic        no_done;

  logic        s_ready, img_wen, acc_start, res_valid, res_match, res_timeout, busy;
  logic [9:0]  img_waddr;
  logic [31:0] img_wdata;
  logic [3:0]  res_predict, res_label;
  logic [15:0] err_cnt, iter_cnt;

  logic        s_ready_t, img_wen_t, acc_start_t, res_valid_t, res_match_t, res_timeout_t, busy_t;
  logic [9:0]  img_waddr_t;
  logic [31:0] img_wdata_t;
  logic [3:0]  res_predict_t, res_label_t;
  logic [15:0] err_cnt_t, iter_cnt_t;

  infer_frame_host dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .img_wen(img_wen), .img_waddr(img_waddr), .img_wdata(img_wdata),
    .acc_start(acc_start), .acc_done(acc_done), .acc_predict(acc_predict),
    .res_valid(res_valid), .res_predict(res_predict), .res_label(res_label),
    .res_match(res_match), .res_timeout(res_timeout),
    .err_cnt(err_cnt), .iter_cnt(iter_cnt), .busy(busy)
  );

  infer_frame_host #(.TIMEOUT_CYC(20)) dut_to (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready_t), .s_data(s_data),
    .img_wen(img_wen_t), .img_waddr(img_waddr_t), .img_wdata(img_wdata_t),
    .acc_start(acc_start_t), .acc_done(no_done), .acc_predict(acc_predict),
    .res_valid(res_valid_t), .res_predict(res_predict_t), .res_label(res_label_t),
    .res_match(res_match_t), .res_timeout(res_timeout_t),
    .err_cnt(err_cnt_t), .iter_cnt(iter_cnt_t), .busy(busy_t)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [9:0]  wa [0:8191];
  logic [31:0] wd [0:8191];
  int wcnt = 0, st_cnt = 0, st_cyc = 0, rv_cnt = 0, rv_cyc = 0;
  int stt_cyc = 0, rvt_cnt = 0, rvt_cyc = 0;
  int wb, sb, rb, rtb;

  // Monitor: sample 1 time unit after each rising edge
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (img_wen && wcnt < 8192) begin
      wa[wcnt] = img_waddr;
      wd[wcnt] = img_wdata;
      wcnt = wcnt + 1;
    end
    if (acc_start) begin st_cnt = st_cnt + 1; st_cyc = cyc; end
    if (res_valid) begin rv_cnt = rv_cnt + 1; rv_cyc = cyc; end
    if (acc_start_t) stt_cyc = cyc;
    if (res_valid_t) begin rvt_cnt = rvt_cnt + 1; rvt_cyc = cyc; end
  end

  task automatic do_reset();
    rst = 1'b1; s_valid = 1'b0; acc_done = 1'b0;
    repeat (3) @(negedge clk);
    wb = wcnt; sb = st_cnt; rb = rv_cnt; rtb = rvt_cnt;
    checks++;
    if (s_ready !== 1'b0) begin errors++; $display("FAIL rst_s_ready: got %0d expected 0", s_ready); end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (s_ready !== 1'b1) begin errors++; $display("FAIL post_rst_s_ready: got %0d expected 1", s_ready); end
  endtask

  task automatic send_word(input logic [31:0] w, input bit bp);
    int guard = 0;
    while (bp && $urandom_range(0, 1) == 0) begin
      s_valid = 1'b0;
      @(negedge clk);
    end
    s_valid = 1'b1;
    s_data  = w;
    while (!s_ready && guard < 2000) begin @(negedge clk); guard++; end
    if (guard >= 2000) begin
      checks++; errors++;
      $display("FAIL s_ready_timeout: got 0 expected 1");
    end
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic send_frame(input int label, input bit bp, input int nwords);
    for (int i = 0; i < nwords; i++)
      send_word((i < 900) ? 32'(i) : 32'(label), bp);
  endtask

  task automatic verify_writes(input string name);
    int bad = -1;
    checks++;
    if (wcnt - wb != 900) begin
      errors++; $display("FAIL %s_write_count: got %0d expected 900", name, wcnt - wb);
    end
    for (int i = 0; i < 900 && wb + i < wcnt; i++)
      if (bad < 0 && (wa[wb+i] !== 10'(i) || wd[wb+i] !== 32'(i))) bad = i;
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s_write_seq: got addr %0d data %0d expected %0d", name, wa[wb+bad], wd[wb+bad], bad);
    end
  endtask

  // Waits for acc_start, answers after dly cycles, then checks the reported result and counters
  task automatic verify_result(input string name, input logic [3:0] pred, input int dly,
                               input logic [3:0] lbl, input logic exp_match, input int exp_err);
    int guard = 0;
    int c;
    while (st_cnt == sb && guard < 100) begin @(negedge clk); guard++; end
    checks++;
    if (st_cnt - sb != 1) begin errors++; $display("FAIL %s_start_count: got %0d expected 1", name, st_cnt - sb); end
    repeat (dly) @(negedge clk);
    acc_done = 1'b1; acc_predict = pred; c = cyc;
    guard = 0;
    while (rv_cnt == rb && guard < 100) begin @(negedge clk); guard++; end
    acc_done = 1'b0;
    checks++;
    if (rv_cyc !== c + 1 || rv_cnt - rb != 1) begin
      errors++; $display("FAIL %s_res_valid_cycle: got %0d expected %0d", name, rv_cyc, c + 1);
    end
    checks++;
    if (res_match !== exp_match || res_predict !== pred || res_label !== lbl || res_timeout !== 1'b0) begin
      errors++;
      $display("FAIL %s_result: got match %0d pred %0d label %0d to %0d expected %0d %0d %0d 0",
               name, res_match, res_predict, res_label, res_timeout, exp_match, pred, lbl);
    end
    @(negedge clk);
    checks++;
    if (err_cnt !== 16'(exp_err) || iter_cnt !== 16'd1 || s_ready !== 1'b1 || res_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_counters: got err %0d iter %0d ready %0d rv %0d expected %0d 1 1 0",
               name, err_cnt, iter_cnt, s_ready, res_valid, exp_err);
    end
    checks++;
    if (st_cnt - sb != 1) begin errors++; $display("FAIL %s_single_start: got %0d expected 1", name, st_cnt - sb); end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (img_wen !== 1'b0 || img_waddr !== 10'd0 || img_wdata !== 32'd0 || acc_start !== 1'b0 ||
        res_valid !== 1'b0 || res_predict !== 4'd0 || res_label !== 4'd0 || res_match !== 1'b0 ||
        res_timeout !== 1'b0 || err_cnt !== 16'd0 || iter_cnt !== 16'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: got wen %0d addr %0d data %0d start %0d rv %0d err %0d iter %0d busy %0d expected all 0",
               img_wen, img_waddr, img_wdata, acc_start, res_valid, err_cnt, iter_cnt, busy);
    end
  endtask

  task automatic test_match();
    int f;
    do_reset();
    f = cyc;
    send_frame(7, 1'b0, 901);
    checks++;
    if (st_cyc !== f + 901) begin errors++; $display("FAIL match_start_latency: got %0d expected %0d", st_cyc - f, 901); end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL match_busy: got %0d expected 1", busy); end
    verify_result("match", 4'd7, 50, 4'd7, 1'b1, 0);
    verify_writes("match");
  endtask

  task automatic test_mismatch();
    do_reset();
    send_frame(3, 1'b0, 901);
    verify_result("mismatch", 4'd5, 10, 4'd3, 1'b0, 1);
  endtask

  task automatic test_backpressure();
    do_reset();
    send_frame(7, 1'b1, 901);
    verify_result("backpressure", 4'd7, 50, 4'd7, 1'b1, 0);
    verify_writes("backpressure");
  endtask

  task automatic test_stale_done();
    int guard = 0;
    do_reset();
    acc_done = 1'b1; acc_predict = 4'd7;
    send_frame(7, 1'b0, 901);
    checks++;
    if (rv_cnt != rb || st_cnt - sb != 1) begin
      errors++; $display("FAIL stale_early_result: got rv %0d start %0d expected 0 1", rv_cnt - rb, st_cnt - sb);
    end
    while (rv_cnt == rb && guard < 100) begin @(negedge clk); guard++; end
    acc_done = 1'b0;
    checks++;
    if (rv_cyc !== st_cyc + 2 || res_match !== 1'b1) begin
      errors++; $display("FAIL stale_wait_len: got %0d match %0d expected 2 1", rv_cyc - st_cyc, res_match);
    end
  endtask

  task automatic test_timeout();
    int guard = 0;
    do_reset();
    acc_predict = 4'd7;
    send_frame(7, 1'b0, 901);
    while (rvt_cnt == rtb && guard < 200) begin @(negedge clk); guard++; end
    checks++;
    if (rvt_cnt - rtb != 1 || rvt_cyc !== stt_cyc + 21) begin
      errors++; $display("FAIL timeout_cycle: got %0d expected 21", rvt_cyc - stt_cyc);
    end
    checks++;
    if (res_timeout_t !== 1'b1 || res_match_t !== 1'b0 || res_predict_t !== 4'd0 || res_label_t !== 4'd7) begin
      errors++;
      $display("FAIL timeout_result: got to %0d match %0d pred %0d label %0d expected 1 0 0 7",
               res_timeout_t, res_match_t, res_predict_t, res_label_t);
    end
    @(negedge clk);
    checks++;
    if (err_cnt_t !== 16'd1 || iter_cnt_t !== 16'd1) begin
      errors++; $display("FAIL timeout_counters: got err %0d iter %0d expected 1 1", err_cnt_t, iter_cnt_t);
    end
    checks++;
    if (rv_cnt != rb || busy !== 1'b1) begin
      errors++; $display("FAIL timeout_long_wait: got rv %0d busy %0d expected 0 1", rv_cnt - rb, busy);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    send_frame(7, 1'b0, 400);
    do_reset();
    checks++;
    if (err_cnt !== 16'd0 || iter_cnt !== 16'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL midrst_counters: got err %0d iter %0d busy %0d expected 0 0 0", err_cnt, iter_cnt, busy);
    end
    send_frame(7, 1'b0, 901);
    verify_result("midrst", 4'd7, 5, 4'd7, 1'b1, 0);
    verify_writes("midrst");
  endtask

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = '0;
    acc_done = 1'b0; acc_predict = '0; no_done = 1'b0;
    @(negedge clk);
    test_reset();
    test_match();
    test_mismatch();
    test_backpressure();
    test_stale_done();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/infer_frame_host.md
# infer_frame_host

Hardware host controller for the accelerator `Top`. It accepts a stream of image frames, each 900 pixel words followed by one label word. For each frame it writes the image into the image BRAM, pulses `start` to the accelerator, and waits for `done`. It then compares `predict` against the label and reports per-frame results plus running error and iteration counts. It replaces the simulation-only load/start/compare loop so that on-board runs need no testbench.

## Interface
Parameters:
- IMG_WORDS, 900, image words per frame; image BRAM address range is 0..IMG_WORDS-1
- ADDR_W, 10, image BRAM address width
- DATA_W, 32, stream and image BRAM data width
- PS_W, 4, predict and label width
- CNT_W, 16, width of the error and iteration counters
- TIMEOUT_CYC, 1000000, maximum number of cycles spent in WAIT before the frame is declared timed out

Ports:
- clk  in  1  single clock; all logic is on the rising edge
- rst  in  1  synchronous, active-high reset
- s_valid  in  1  input stream word valid
- s_ready  out  1  input stream ready
- s_data  in  DATA_W  input stream word; the label is taken from s_data[PS_W-1:0] of the 901st word of a frame
- img_wen  out  1  image BRAM write enable
- img_waddr  out  ADDR_W  image BRAM write address
- img_wdata  out  DATA_W  image BRAM write data
- acc_start  out  1  start pulse to the accelerator
- acc_done  in  1  done from the accelerator, level-sensitive
- acc_predict  in  PS_W  accelerator prediction
- res_valid  out  1  one-cycle pulse marking a frame result
- res_predict  out  PS_W  captured prediction
- res_label  out  PS_W  captured label
- res_match  out  1  res_predict == res_label and no timeout
- res_timeout  out  1  the frame timed out
- err_cnt  out  CNT_W  frames with no match, saturating
- iter_cnt  out  CNT_W  frames completed, saturating
- busy  out  1  high in START and WAIT

## Operation
- FSM states: LOAD, LABEL, START, WAIT, REPORT.
- **LOAD**
  - s_ready = 1.
  - Each handshake (s_valid & s_ready) writes s_data to address pix_cnt; pix_cnt then increments.
  - On the handshake with pix_cnt == IMG_WORDS-1: go to LABEL and clear pix_cnt.
- **LABEL**
  - s_ready = 1.
  - On handshake: capture the label from s_data[PS_W-1:0] and go to START.
- **START**
  - s_ready = 0; acc_start = 1 for exactly this one cycle.
  - Clear the timeout counter and go to WAIT.
- **WAIT**
  - s_ready = 0; the timeout counter increments every cycle.
  - First cycle with acc_done = 1: capture acc_predict into res_predict, set res_timeout = 0, go to REPORT.
  - Timeout counter == TIMEOUT_CYC-1 with acc_done = 0: set res_timeout = 1, keep the previous res_predict, go to REPORT.
  - acc_done is ignored in every state other than WAIT.
- **REPORT**
  - res_valid = 1 for one cycle.
  - iter_cnt increments.
  - err_cnt increments when res_match = 0.
  - Both counters hold at all-ones rather than wrapping.
  - Go to LOAD.
- Image writes are registered: img_wen, img_waddr and img_wdata are asserted in the cycle after the handshake. The last image write therefore always completes before acc_start.
- res_predict, res_label, res_match and res_timeout hold their values until the next REPORT.
- Reset at any point, including mid-frame: return to LOAD with pix_cnt = 0. Partially loaded frames are discarded.

## Timing
- Reset values:
  - state = LOAD, s_ready = 0 while rst = 1, s_ready = 1 in the first cycle after rst falls.
  - img_wen = 0, img_waddr = 0, img_wdata = 0.
  - acc_start = 0, res_valid = 0, res_predict = 0, res_label = 0, res_match = 0, res_timeout = 0.
  - err_cnt = 0, iter_cnt = 0, busy = 0.
- With no backpressure, the minimum frame intake is 901 cycles.
- acc_start is asserted 1 cycle after the label handshake.
- res_valid is asserted 1 cycle after the WAIT cycle that sees acc_done = 1.
- The first s_ready of the next frame is asserted 1 cycle after res_valid.
- Gaps in s_valid stall the counters. No word is lost or duplicated.
- If acc_done is already high on the first WAIT cycle, it is accepted immediately (WAIT lasts 1 cycle).

## Test plan
- **Single frame, match:** words 0..899 = index, label word = 7; drive acc_done = 1 with acc_predict = 7, 50 cycles after acc_start.
  - Required: 900 writes with img_waddr 0..899 and img_wdata equal to the index.
  - Required: exactly one acc_start pulse.
  - Required: res_valid with res_match = 1, err_cnt = 0, iter_cnt = 1.
- **Mismatch:** label = 3, acc_predict = 5.
  - Required: res_match = 0, err_cnt = 1, iter_cnt = 1.
- **Backpressure:** s_valid toggles randomly at 50% duty.
  - Required: write sequence identical to the match test and a frame result identical to it.
- **Stale done:** acc_done held at 1 during LOAD.
  - Required: no state change and no res_valid until START and WAIT are reached.
- **Timeout:** TIMEOUT_CYC = 20, acc_done never asserted.
  - Required: res_valid 20 cycles after entering WAIT, with res_timeout = 1, res_match = 0, err_cnt = 1.
- **Reset mid-frame:** assert rst after 400 words, then send a full frame.
  - Required: the next writes start at address 0, counters read 0, and the frame completes normally.
